// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall sequencer driving the 5-stage pipeline latch enables and bubbles.
// Tracks multi-cycle mult/div waits, a saturating stall counter and a sticky timeout flag.
module pipe_stall_ctrl #(
    parameter int MD_MAX = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             hold_i,
    input  logic             load_use_hz_i,
    input  logic             branch_taken_i,
    input  logic             md_start_i,
    input  logic             md_ready_i,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             dx_en_o,
    output logic             xm_en_o,
    output logic             mw_en_o,
    output logic             fd_bubble_o,
    output logic             dx_bubble_o,
    output logic             xm_bubble_o,
    output logic             md_busy_o,
    output logic             md_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam int MW = $clog2(MD_MAX);

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             md_timeout_q, md_timeout_d;
    logic             act, run, wait_st, last, md_stall, br, lu;

    always_comb begin
        act          = reset_ni & ~hold_i;
        run          = (state_q == RUN);
        wait_st      = (state_q == MD_WAIT);
        last         = (md_cnt_q == MW'(MD_MAX - 1));
        // md_start owns RUN priority even when md_ready lands the same cycle
        md_stall     = (run & md_start_i & ~md_ready_i) | (wait_st & ~md_ready_i & ~last);
        br           = run & ~md_start_i & branch_taken_i;
        lu           = run & ~md_start_i & ~branch_taken_i & load_use_hz_i;
        pc_en_o      = act & ~md_stall & ~lu;
        fd_en_o      = act & ~md_stall & ~lu;
        dx_en_o      = act & ~md_stall;
        xm_en_o      = act;
        mw_en_o      = act;
        fd_bubble_o  = act & br;
        dx_bubble_o  = act & (br | lu);
        xm_bubble_o  = act & md_stall;
        md_busy_o    = wait_st;
        md_timeout_o = md_timeout_q;
        stall_cnt_o  = stall_cnt_q;
        state_d      = md_stall ? MD_WAIT : RUN;
        md_cnt_d     = (wait_st & md_stall) ? md_cnt_q + MW'(1) : '0;
        md_timeout_d = md_timeout_q | (wait_st & ~md_ready_i & last);
        stall_cnt_d  = (~pc_en_o & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= RUN;
            md_cnt_q     <= '0;
            stall_cnt_q  <= '0;
            md_timeout_q <= 1'b0;
        end else if (!hold_i) begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vectors with a scoreboard queue; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;
    localparam int CW = 4;

    typedef struct packed {
        logic [4:0]    en;
        logic [2:0]    bub;
        logic          busy;
        logic          to;
        logic [CW-1:0] cnt;
    } exp_t;

    localparam logic [4:0] EA = 5'b11111, EN = 5'b00000, EM = 5'b00011, EL = 5'b00111;
    localparam logic [2:0] B0 = 3'b000, BM = 3'b001, BL = 3'b010, BB = 3'b110;

    logic clk = 1'b0;
    logic reset_n = 1'b0, hold = 1'b0, lu = 1'b0, br = 1'b0, ms = 1'b0, mr = 1'b0;
    logic pc_en, fd_en, dx_en, xm_en, mw_en, fd_b, dx_b, xm_b, busy, tmo;
    logic [CW-1:0] scnt;
    exp_t q[$];
    logic [CW-1:0] exp_cnt = '0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_MAX(8), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_ni(reset_n), .hold_i(hold), .load_use_hz_i(lu),
        .branch_taken_i(br), .md_start_i(ms), .md_ready_i(mr),
        .pc_en_o(pc_en), .fd_en_o(fd_en), .dx_en_o(dx_en), .xm_en_o(xm_en), .mw_en_o(mw_en),
        .fd_bubble_o(fd_b), .dx_bubble_o(dx_b), .xm_bubble_o(xm_b),
        .md_busy_o(busy), .md_timeout_o(tmo), .stall_cnt_o(scnt)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 3;
            if ({pc_en, fd_en, dx_en, xm_en, mw_en, fd_b, dx_b, xm_b} !== {e.en, e.bub}) begin
                errors++;
                $display("FAIL en_bub t=%0t got=%b exp=%b", $time,
                         {pc_en, fd_en, dx_en, xm_en, mw_en, fd_b, dx_b, xm_b}, {e.en, e.bub});
            end
            if ({busy, tmo} !== {e.busy, e.to}) begin
                errors++;
                $display("FAIL busy_to t=%0t got=%b exp=%b", $time, {busy, tmo}, {e.busy, e.to});
            end
            if (scnt !== e.cnt) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, scnt, e.cnt);
            end
        end
    end

    // args: reset_n, hold, load_use, branch, md_start, md_ready, exp en, exp bubbles, exp busy, exp timeout
    task automatic step(input logic r, h, l, b, s, m, input logic [4:0] en, input logic [2:0] bub,
                        input logic bsy, input logic t);
        reset_n = r; hold = h; lu = l; br = b; ms = s; mr = m;
        q.push_back('{en: en, bub: bub, busy: bsy, to: t, cnt: exp_cnt});
        @(posedge clk);
        #1;
        if (!r) exp_cnt = '0;
        else if (!h && !en[4] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // 1: reset dominates md_start/load-use
        step(0, 0, 1, 0, 1, 0, EN, B0, 0, 0);
        step(0, 0, 1, 0, 1, 0, EN, B0, 0, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        // 2: load-use
        step(1, 0, 1, 0, 0, 0, EL, BL, 0, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        // 3: branch beats load-use
        step(1, 0, 1, 1, 0, 0, EA, BB, 0, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        // 4: mult/div with ready at cycle 5
        step(1, 0, 0, 0, 1, 0, EM, BM, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0, EM, BM, 1, 0);
        step(1, 0, 0, 0, 0, 1, EA, B0, 1, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        // 5: forced release on the 8th wait cycle, sticky flag
        step(1, 0, 0, 0, 1, 0, EM, BM, 0, 0);
        repeat (7) step(1, 0, 0, 0, 0, 0, EM, BM, 1, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 1, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 1);
        step(1, 0, 1, 0, 0, 0, EL, BL, 0, 1);
        step(1, 0, 0, 1, 0, 0, EA, BB, 0, 1);
        step(1, 0, 0, 0, 1, 1, EA, B0, 0, 1);
        step(0, 0, 0, 0, 0, 0, EN, B0, 0, 1);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        // ready on the last allowed cycle is a normal release
        step(1, 0, 0, 0, 1, 0, EM, BM, 0, 0);
        repeat (7) step(1, 0, 0, 0, 0, 0, EM, BM, 1, 0);
        step(1, 0, 0, 0, 0, 1, EA, B0, 1, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        // 6: hold inside the wait freezes md_cnt at 2 and the stall counter
        step(0, 0, 0, 0, 0, 0, EN, B0, 0, 0);
        step(1, 0, 0, 0, 1, 0, EM, BM, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, EM, BM, 1, 0);
        repeat (3) step(1, 1, 1, 1, 0, 1, EN, B0, 1, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0, EM, BM, 1, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 1, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 1);
        // saturation
        step(0, 0, 0, 0, 0, 0, EN, B0, 0, 1);
        repeat (18) step(1, 0, 1, 0, 0, 0, EL, BL, 0, 0);
        step(1, 0, 0, 0, 0, 0, EA, B0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
